// File: rtl/riscv_defines.sv
// Shared definitions for the fetch stage: bubble encoding and fetch FSM states.
package riscv_defines;

    // addi x0, x0, 0 -- canonical RISC-V NOP used as the pipeline bubble
    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_REQ,
        IF_WAIT,
        IF_HOLD
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request/grant/rvalid memory
// interface, PC sequencing, branch redirect and a one-entry hold register
// that keeps the fetched word stable while the decode stage is stalled.
module if_stage
    import riscv_defines::*;
#(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = WORD_WIDTH'(RV_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [WORD_WIDTH-1:0] branch_target_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic [WORD_WIDTH-1:0] program_count_o,
    output logic [WORD_WIDTH-1:0] pc_plus4_o,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic                  no_op_flag_o
);

    localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

    if_state_e             state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] hold_q, hold_d;
    logic                  redir_pend_q, redir_pend_d;
    logic [WORD_WIDTH-1:0] redir_tgt_q, redir_tgt_d;
    logic                  started_q, started_d;

    logic [WORD_WIDTH-1:0] start_aligned;
    logic [WORD_WIDTH-1:0] target_aligned;

    assign start_aligned   = {pc_start_addr_i[WORD_WIDTH-1:2], 2'b00};
    assign target_aligned  = {branch_target_i[WORD_WIDTH-1:2], 2'b00};
    assign program_count_o = pc_q;
    assign pc_plus4_o      = pc_q + PC_STEP;

    // State, PC, hold and pending-redirect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IF_IDLE;
            pc_q         <= '0;
            hold_q       <= NOP_INSTR;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            started_q    <= started_d;
        end
    end

    // Next-state, PC update and output selection
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;
        started_d     = started_q;
        instr_req_o   = 1'b0;
        instr_addr_o  = '0;
        instruction_o = NOP_INSTR;
        no_op_flag_o  = 1'b1;

        unique case (state_q)
            IF_IDLE: begin
                // Boot PC tracks the input only until the first fetch starts
                if (!started_q) begin
                    pc_d = start_aligned;
                end
                if (branch_taken_i) begin
                    pc_d      = target_aligned;
                    hold_d    = NOP_INSTR;
                    started_d = 1'b1;
                    state_d   = IF_REQ;
                end else if (fetch_en_i) begin
                    started_d = 1'b1;
                    state_d   = IF_REQ;
                end
            end

            IF_REQ: begin
                // Address must stay stable until granted, so a redirect is
                // parked and applied once this request's response returns
                instr_req_o  = 1'b1;
                instr_addr_o = pc_q;
                if (branch_taken_i) begin
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = target_aligned;
                end
                if (instr_gnt_i) begin
                    state_d = IF_WAIT;
                end
            end

            IF_WAIT: begin
                if (branch_taken_i) begin
                    pc_d         = target_aligned;
                    redir_pend_d = 1'b0;
                    hold_d       = NOP_INSTR;
                    state_d      = IF_REQ;
                end else if (instr_rvalid_i) begin
                    if (redir_pend_q) begin
                        pc_d         = redir_tgt_q;
                        redir_pend_d = 1'b0;
                        state_d      = IF_REQ;
                    end else begin
                        instruction_o = instr_rdata_i;
                        no_op_flag_o  = 1'b0;
                        if (stall_i) begin
                            hold_d  = instr_rdata_i;
                            state_d = IF_HOLD;
                        end else begin
                            pc_d    = pc_q + PC_STEP;
                            state_d = fetch_en_i ? IF_REQ : IF_IDLE;
                        end
                    end
                end
            end

            IF_HOLD: begin
                if (branch_taken_i) begin
                    pc_d    = target_aligned;
                    hold_d  = NOP_INSTR;
                    state_d = IF_REQ;
                end else begin
                    instruction_o = hold_q;
                    no_op_flag_o  = 1'b0;
                    if (!stall_i) begin
                        pc_d    = pc_q + PC_STEP;
                        hold_d  = NOP_INSTR;
                        state_d = fetch_en_i ? IF_REQ : IF_IDLE;
                    end
                end
            end

            default: state_d = IF_IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: boot sequencing, grant delay, stall/hold,
// branch redirects, PC wrap and reset during an outstanding request.
module tb_if_stage;

    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          fetch_en_i;
    logic [W-1:0]  pc_start_addr_i;
    logic          stall_i;
    logic          branch_taken_i;
    logic [W-1:0]  branch_target_i;
    logic          instr_req_o;
    logic [W-1:0]  instr_addr_o;
    logic          instr_gnt_i;
    logic          instr_rvalid_i;
    logic [W-1:0]  instr_rdata_i;
    logic [W-1:0]  program_count_o;
    logic [W-1:0]  pc_plus4_o;
    logic [W-1:0]  instruction_o;
    logic          no_op_flag_o;

    int checks = 0;
    int errors = 0;

    if_stage #(
        .WORD_WIDTH (W),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en_i      (fetch_en_i),
        .pc_start_addr_i (pc_start_addr_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .program_count_o (program_count_o),
        .pc_plus4_o      (pc_plus4_o),
        .instruction_o   (instruction_o),
        .no_op_flag_o    (no_op_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled mid-low-phase
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [W-1:0] start);
        rst_n = 1'b0;
        fetch_en_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        pc_start_addr_i = start;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_en_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
        branch_target_i = '0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; pc_start_addr_i = 32'h100;
        cyc();
        #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", instr_addr_o); end
        checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h exp %h", instruction_o, NOP); end
        checks++; if (no_op_flag_o !== 1'b1) begin errors++; $display("FAIL reset_nop: got %0b exp 1", no_op_flag_o); end
        checks++; if (program_count_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", program_count_o); end
        checks++; if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h exp 4", pc_plus4_o); end
    endtask

    task automatic test_sequential();
        logic [W-1:0] a;
        do_reset(32'h100);
        fetch_en_i = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            a = 32'h100 + 32'(4 * k);
            #1;
            checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== a) begin errors++; $display("FAIL seq_req%0d: got req=%0b addr=%h exp req=1 addr=%h", k, instr_req_o, instr_addr_o, a); end
            cyc();
            instr_gnt_i = 1'b1;
            cyc();
            instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h1000 + 32'(k);
            #1;
            checks++; if (instruction_o !== (32'h1000 + 32'(k)) || no_op_flag_o !== 1'b0) begin errors++; $display("FAIL seq_data%0d: got %h nop=%0b exp %h nop=0", k, instruction_o, no_op_flag_o, 32'h1000 + 32'(k)); end
            checks++; if (program_count_o !== a || pc_plus4_o !== a + 32'h4) begin errors++; $display("FAIL seq_pc%0d: got pc=%h pc4=%h exp pc=%h pc4=%h", k, program_count_o, pc_plus4_o, a, a + 32'h4); end
            cyc();
            instr_rvalid_i = 1'b0;
        end
        // Disable mid-transaction: request at 0x10C completes, then idle
        fetch_en_i = 1'b0;
        instr_gnt_i = 1'b1;
        cyc();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h2222;
        #1;
        checks++; if (instruction_o !== 32'h2222) begin errors++; $display("FAIL seq_lastdata: got %h exp 2222", instruction_o); end
        cyc();
        instr_rvalid_i = 1'b0;
        cyc();
        #1;
        checks++; if (instr_req_o !== 1'b0 || program_count_o !== 32'h110) begin errors++; $display("FAIL seq_idle: got req=%0b pc=%h exp req=0 pc=110", instr_req_o, program_count_o); end
    endtask

    task automatic test_gnt_delay();
        do_reset(32'h100);
        fetch_en_i = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) instr_gnt_i = 1'b1;
            #1;
            checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin errors++; $display("FAIL gnt_stable%0d: got req=%0b addr=%h exp req=1 addr=100", i, instr_req_o, instr_addr_o); end
            cyc();
        end
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hA5A5_0001;
        #1;
        checks++; if (instr_req_o !== 1'b0 || instruction_o !== 32'hA5A5_0001 || program_count_o !== 32'h100) begin errors++; $display("FAIL gnt_resp: got req=%0b instr=%h pc=%h exp req=0 instr=a5a50001 pc=100", instr_req_o, instruction_o, program_count_o); end
        cyc();
        instr_rvalid_i = 1'b0;
        #1;
        checks++; if (instr_addr_o !== 32'h104) begin errors++; $display("FAIL gnt_next: got %h exp 104", instr_addr_o); end
    endtask

    task automatic test_stall();
        // Continues from REQ at 0x104
        instr_gnt_i = 1'b1;
        cyc();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF; stall_i = 1'b1;
        #1;
        checks++; if (instruction_o !== 32'hDEAD_BEEF || no_op_flag_o !== 1'b0) begin errors++; $display("FAIL stall_wait: got %h nop=%0b exp deadbeef nop=0", instruction_o, no_op_flag_o); end
        cyc();
        instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0BAD_0BAD;
        #1;
        checks++; if (instruction_o !== 32'hDEAD_BEEF || no_op_flag_o !== 1'b0 || instr_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold1: got %h nop=%0b req=%0b exp deadbeef 0 0", instruction_o, no_op_flag_o, instr_req_o); end
        cyc();
        stall_i = 1'b0;
        #1;
        checks++; if (instruction_o !== 32'hDEAD_BEEF || instr_req_o !== 1'b0 || program_count_o !== 32'h104) begin errors++; $display("FAIL stall_hold2: got %h req=%0b pc=%h exp deadbeef 0 104", instruction_o, instr_req_o, program_count_o); end
        cyc();
        #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h108 || no_op_flag_o !== 1'b1) begin errors++; $display("FAIL stall_resume: got req=%0b addr=%h nop=%0b exp 1 108 1", instr_req_o, instr_addr_o, no_op_flag_o); end
    endtask

    task automatic test_branch_in_req();
        do_reset(32'h200);
        fetch_en_i = 1'b1;
        cyc();
        branch_taken_i = 1'b1; branch_target_i = 32'h403;
        #1;
        checks++; if (instr_addr_o !== 32'h200) begin errors++; $display("FAIL br_req_addr: got %h exp 200", instr_addr_o); end
        cyc();
        branch_taken_i = 1'b0; branch_target_i = 32'h0;
        #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin errors++; $display("FAIL br_req_hold: got req=%0b addr=%h exp 1 200", instr_req_o, instr_addr_o); end
        instr_gnt_i = 1'b1;
        cyc();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h1111_1111;
        #1;
        checks++; if (no_op_flag_o !== 1'b1 || instruction_o !== NOP) begin errors++; $display("FAIL br_req_bubble: got %h nop=%0b exp %h nop=1", instruction_o, no_op_flag_o, NOP); end
        cyc();
        instr_rvalid_i = 1'b0;
        #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h400) begin errors++; $display("FAIL br_req_target: got req=%0b addr=%h exp 1 400", instr_req_o, instr_addr_o); end
    endtask

    task automatic test_branch_with_rvalid();
        // Continues from REQ at 0x400
        instr_gnt_i = 1'b1;
        cyc();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h7777_7777;
        branch_taken_i = 1'b1; branch_target_i = 32'h800;
        #1;
        checks++; if (no_op_flag_o !== 1'b1 || instruction_o !== NOP) begin errors++; $display("FAIL br_rv_bubble: got %h nop=%0b exp %h nop=1", instruction_o, no_op_flag_o, NOP); end
        cyc();
        instr_rvalid_i = 1'b0; branch_taken_i = 1'b0;
        #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h800) begin errors++; $display("FAIL br_rv_target: got req=%0b addr=%h exp 1 800", instr_req_o, instr_addr_o); end
    endtask

    task automatic test_reset_in_wait();
        // Continues from REQ at 0x800
        instr_gnt_i = 1'b1;
        cyc();
        instr_gnt_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0 || program_count_o !== 32'h0 || pc_plus4_o !== 32'h4) begin errors++; $display("FAIL rstw_async: got req=%0b addr=%h pc=%h pc4=%h exp 0 0 0 4", instr_req_o, instr_addr_o, program_count_o, pc_plus4_o); end
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hCAFE_F00D;
        #1;
        checks++; if (instruction_o !== NOP || no_op_flag_o !== 1'b1) begin errors++; $display("FAIL rstw_drop: got %h nop=%0b exp %h nop=1", instruction_o, no_op_flag_o, NOP); end
        cyc();
        fetch_en_i = 1'b0; rst_n = 1'b1;
        #1;
        checks++; if (instruction_o !== NOP || no_op_flag_o !== 1'b1 || instr_req_o !== 1'b0) begin errors++; $display("FAIL rstw_after: got %h nop=%0b req=%0b exp %h 1 0", instruction_o, no_op_flag_o, instr_req_o, NOP); end
        cyc();
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC);
        fetch_en_i = 1'b1;
        cyc();
        #1;
        checks++; if (instr_addr_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_top: got addr=%h pc4=%h exp fffffffc 0", instr_addr_o, pc_plus4_o); end
        instr_gnt_i = 1'b1;
        cyc();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h3333;
        cyc();
        instr_rvalid_i = 1'b0;
        #1;
        checks++; if (instr_addr_o !== 32'h0 || program_count_o !== 32'h0) begin errors++; $display("FAIL wrap_zero: got addr=%h pc=%h exp 0 0", instr_addr_o, program_count_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_gnt_delay();
        test_stall();
        test_branch_in_req();
        test_branch_with_rvalid();
        test_reset_in_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
